// File: rtl/radix4_div_36by18_if.sv
// Bundle of request, result and status signals of the radix-4 2N-by-N divider.
// start is a single-cycle request, honoured only while busy=0; q/r/ovf are valid when done=1 and hold afterwards.
`timescale 1ns/1ps
interface radix4_div_36by18_if #(
    parameter int N = 18
);
    logic           start;
    logic [2*N-1:0] x;
    logic [N-1:0]   y;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           busy;
    logic           done;
    logic           ovf;
    logic [1:0]     state;

    modport master (
        output start, x, y,
        input  q, r, busy, done, ovf, state
    );

    modport slave (
        input  start, x, y,
        output q, r, busy, done, ovf, state
    );
endinterface

// File: rtl/radix4_div_36by18.sv
// Unsigned 2N-by-N restoring divider retiring two quotient bits per cycle.
// Overflow or divide-by-zero is detected up front and reported without iterating.
`timescale 1ns/1ps
module radix4_div_36by18 #(
    parameter int N = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    radix4_div_36by18_if.slave    bus
);
    localparam int ITERS = N / 2;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [N-1:0]  pr;
    logic [N-1:0]  lo;
    logic [N-1:0]  yr;
    logic [N-1:0]  qs;
    logic [N-1:0]  q_r;
    logic [N-1:0]  r_r;
    logic          ovf_r;

    logic          err;
    logic          last;
    logic [N+1:0]  w;
    logic [N+1:0]  y1;
    logic [N+1:0]  y2;
    logic [N+1:0]  y3;
    logic [1:0]    digit;
    logic [N-1:0]  sub;
    logic [N-1:0]  rem_next;

    // The quotient only fits in N bits when the high dividend half is below the divisor.
    assign err  = (bus.y == '0) || (bus.x[2*N-1:N] >= bus.y);
    assign last = (cnt == CW'(ITERS - 1));
    assign w    = {pr, lo[N-1:N-2]};
    assign y1   = {2'b00, yr};
    assign y2   = {1'b0, yr, 1'b0};
    assign y3   = y1 + y2;

    // The remainder is known to fit in N bits, so the subtract runs on the low N bits only.
    always_comb begin
        digit = 2'd0;
        sub   = '0;
        if (w >= y3)      digit = 2'd3;
        else if (w >= y2) digit = 2'd2;
        else if (w >= y1) digit = 2'd1;
        case (digit)
            2'd3:    sub = y3[N-1:0];
            2'd2:    sub = y2[N-1:0];
            2'd1:    sub = y1[N-1:0];
            default: sub = '0;
        endcase
        rem_next = w[N-1:0] - sub;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = err ? DONE : CALC;
            CALC:    if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            pr    <= '0;
            lo    <= '0;
            yr    <= '0;
            qs    <= '0;
            q_r   <= '0;
            r_r   <= '0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt <= '0;
                        yr  <= bus.y;
                        pr  <= bus.x[2*N-1:N];
                        lo  <= bus.x[N-1:0];
                        qs  <= '0;
                        if (err) begin
                            q_r   <= '1;
                            r_r   <= '0;
                            ovf_r <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    pr  <= rem_next;
                    lo  <= {lo[N-3:0], 2'b00};
                    qs  <= {qs[N-3:0], digit};
                    if (last) begin
                        q_r   <= {qs[N-3:0], digit};
                        r_r   <= rem_next;
                        ovf_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.q     = q_r;
    assign bus.r     = r_r;
    assign bus.ovf   = ovf_r;
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.state = state;
endmodule

// File: tb/tb_radix4_div_36by18.sv
// Bench for radix4_div_36by18: directed corner cases, operand sampling, reset abort,
// and randomized back-to-back divisions against an arithmetic reference.
`timescale 1ns/1ps
module tb_radix4_div_36by18;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [36:0] exp_q[$];

    radix4_div_36by18_if #(.N(18)) bus ();

    radix4_div_36by18 #(.N(18)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result layout {ovf, q, r}, from plain integer division.
    function automatic logic [36:0] model(input logic [35:0] xv, input logic [17:0] yv);
        longint unsigned xx;
        longint unsigned yy;
        longint unsigned qq;
        xx = 64'(xv);
        yy = 64'(yv);
        if (yy == 0) return {1'b1, 18'h3FFFF, 18'h0};
        qq = xx / yy;
        if (qq > 64'd262143) return {1'b1, 18'h3FFFF, 18'h0};
        return {1'b0, 18'(qq), 18'(xx % yy)};
    endfunction

    // Called just after an accepting edge; returns in the cycle where done is high.
    task automatic wait_result(output logic [17:0] qo, output logic [17:0] ro,
                               output logic ovo, output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 30) begin
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_during_op: busy=%0b required 1 (cycle %0d)", bus.busy, lat);
            end
            bus.x = {4'($urandom), $urandom};
            bus.y = 18'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", lat);
        end
        qo  = bus.q;
        ro  = bus.r;
        ovo = bus.ovf;
    endtask

    task automatic run_op(input logic [35:0] xv, input logic [17:0] yv,
                          output logic [17:0] qo, output logic [17:0] ro,
                          output logic ovo, output int lat);
        bus.start = 1'b1;
        bus.x     = xv;
        bus.y     = yv;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_result(qo, ro, ovo, lat);
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: done=%0b busy=%0b required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic check_result(input string name, input logic [35:0] xv, input logic [17:0] yv,
                                input logic [17:0] qo, input logic [17:0] ro, input logic ovo,
                                input int lat);
        logic [36:0] e;
        int          elat;
        e    = model(xv, yv);
        elat = e[36] ? 0 : 9;
        checks++;
        if ({ovo, qo, ro} !== e || lat != elat) begin
            errors++;
            $display("FAIL %s: x=%h y=%h got ovf=%0b q=%h r=%h lat=%0d required ovf=%0b q=%h r=%h lat=%0d",
                     name, xv, yv, ovo, qo, ro, lat, e[36], e[35:18], e[17:0], elat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.x = '0;
        bus.y = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.q !== 18'h0 || bus.r !== 18'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: q=%h r=%h busy=%0b done=%0b ovf=%0b required all 0",
                     bus.q, bus.r, bus.busy, bus.done, bus.ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [35:0] xs[6];
        logic [17:0] ys[6];
        logic [17:0] qo, ro;
        logic        ovo;
        logic [36:0] e;
        int          lat;
        xs[0] = 36'd1000;                  ys[0] = 18'd7;
        xs[1] = {18'd4, 18'd0};            ys[1] = 18'd5;
        xs[2] = {4'($urandom), $urandom};  ys[2] = 18'd0;
        xs[3] = {18'h3FFFE, 18'h3FFFF};    ys[3] = 18'h3FFFF;
        xs[4] = {18'd5, 18'd0};            ys[4] = 18'd5;
        xs[5] = 36'd0;                     ys[5] = 18'd1;
        for (int i = 0; i < 6; i++) begin
            run_op(xs[i], ys[i], qo, ro, ovo, lat);
            check_result($sformatf("directed_%0d", i), xs[i], ys[i], qo, ro, ovo, lat);
            repeat (2) @(posedge clk);
            #1;
            e = model(xs[i], ys[i]);
            checks++;
            if ({bus.ovf, bus.q, bus.r} !== e) begin
                errors++;
                $display("FAIL result_hold_%0d: ovf=%0b q=%h r=%h required ovf=%0b q=%h r=%h",
                         i, bus.ovf, bus.q, bus.r, e[36], e[35:18], e[17:0]);
            end
        end
        checks++;
        if (model(36'd1000, 18'd7) !== {1'b0, 18'd142, 18'd6}) begin
            errors++;
            $display("FAIL model_sanity: reference model disagrees with 1000/7=142 r6");
        end
    endtask

    task automatic test_operand_change();
        logic [35:0] xa, xd;
        logic [17:0] ya, yd;
        logic [17:0] qo, ro;
        logic        ovo;
        int          lat;
        ya = 18'($urandom_range(1, 262143));
        xa = {18'($urandom_range(0, int'(ya) - 1)), 18'($urandom)};
        yd = 18'($urandom_range(1, 262143));
        xd = {18'($urandom_range(0, int'(yd) - 1)), 18'($urandom)};
        bus.start = 1'b1;
        bus.x = xa;
        bus.y = ya;
        @(posedge clk); #1;
        wait_result(qo, ro, ovo, lat);
        check_result("operands_sampled_at_accept", xa, ya, qo, ro, ovo, lat);
        bus.x = xd;
        bus.y = yd;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_ignored: busy=%0b done=%0b required 0 0", bus.busy, bus.done);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_in_idle_accepted: busy=%0b required 1", bus.busy);
        end
        bus.start = 1'b0;
        wait_result(qo, ro, ovo, lat);
        check_result("back_to_back_accept", xd, yd, qo, ro, ovo, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic [17:0] qo, ro;
        logic        ovo;
        int          lat;
        int          seen;
        run_op(36'd1000, 18'd7, qo, ro, ovo, lat);
        bus.start = 1'b1;
        bus.x = 36'd123456789;
        bus.y = 18'd1000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.q !== 18'h0 || bus.r !== 18'h0 || bus.done !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_state: busy=%0b q=%h r=%h done=%0b ovf=%0b required all 0",
                     bus.busy, bus.q, bus.r, bus.done, bus.ovf);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_abort_no_done: done seen %0d times required 0", seen);
        end
        bus.start = 1'b1;
        bus.x = 36'd1000;
        bus.y = 18'd7;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_start: busy=%0b required 0", bus.busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int n);
        logic [35:0] xv;
        logic [17:0] yv;
        logic [17:0] qo, ro;
        logic        ovo;
        logic [36:0] e;
        int          lat;
        longint unsigned recon;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                xv = {4'($urandom), $urandom};
                yv = ($urandom_range(0, 3) == 0) ? 18'd0 : 18'($urandom);
            end else begin
                yv = 18'($urandom_range(1, 262143));
                xv = {18'($urandom_range(0, int'(yv) - 1)), 18'($urandom)};
            end
            exp_q.push_back(model(xv, yv));
            run_op(xv, yv, qo, ro, ovo, lat);
            e = exp_q.pop_front();
            checks++;
            if ({ovo, qo, ro} !== e || lat != (e[36] ? 0 : 9)) begin
                errors++;
                $display("FAIL random_%0d: x=%h y=%h got ovf=%0b q=%h r=%h lat=%0d required ovf=%0b q=%h r=%h",
                         i, xv, yv, ovo, qo, ro, lat, e[36], e[35:18], e[17:0]);
            end
            if (!e[36]) begin
                recon = 64'(qo) * 64'(yv) + 64'(ro);
                checks++;
                if (recon != 64'(xv) || ro >= yv) begin
                    errors++;
                    $display("FAIL random_invariant_%0d: q*y+r=%0d x=%0d r=%0d y=%0d", i, recon, xv, ro, yv);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.x = '0;
        bus.y = '0;
        test_reset();
        test_directed();
        test_operand_change();
        test_reset_abort();
        test_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
